// File: rtl/keccak_pi_pkg.sv
// Shared types and constants for the Keccak pi slice engine.
package keccak_pi_pkg;

  localparam int DIM     = 5;
  localparam int SLICE_W = DIM * DIM;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CALC,
    REDUCE,
    WRITE,
    NEXT,
    FIN
  } state_t;

  // Flat bit position of A[i][j] inside a 25-bit slice.
  function automatic logic [4:0] idx(input logic [2:0] i, input logic [2:0] j);
    return {2'b00, i} * 5'd5 + {2'b00, j};
  endfunction

endpackage

// File: rtl/pi_mod5_unit.sv
// Computes (2i + 3j) mod 5 for the current cell, iteratively by default.
// Define MOD_LUT_EN to replace the subtract-5 loop with a single-cycle lookup.
module pi_mod5_unit
  import keccak_pi_pkg::*;
(
  input  logic       clk,
  input  logic       i_calc,
  input  logic       i_reduce,
  input  logic [2:0] i_i,
  input  logic [2:0] i_j,
  output logic [2:0] o_res,
  output logic       o_ge5
);

  localparam logic [4:0] MODV = 5'(DIM);

  logic [4:0] r_acc;
  logic [4:0] w_sum;
  logic [4:0] w_calc;

  assign w_sum = ({2'b00, i_i} << 1) + ({2'b00, i_j} << 1) + {2'b00, i_j};

`ifdef MOD_LUT_EN
  function automatic logic [4:0] mod5_lut(input logic [4:0] v);
    logic [4:0] r;
    case (v)
      5'd0, 5'd5, 5'd10, 5'd15, 5'd20: r = 5'd0;
      5'd1, 5'd6, 5'd11, 5'd16:        r = 5'd1;
      5'd2, 5'd7, 5'd12, 5'd17:        r = 5'd2;
      5'd3, 5'd8, 5'd13, 5'd18:        r = 5'd3;
      5'd4, 5'd9, 5'd14, 5'd19:        r = 5'd4;
      default:                         r = 5'd0;
    endcase
    return r;
  endfunction

  assign w_calc = mod5_lut(w_sum);
`else
  assign w_calc = w_sum;
`endif

  // acc is pure datapath: it is always rewritten by CALC before use.
  always_ff @(posedge clk) begin
    if (i_calc) begin
      r_acc <= w_calc;
    end else if (i_reduce && (r_acc >= MODV)) begin
      r_acc <= r_acc - MODV;
    end
  end

  assign o_ge5 = (r_acc >= MODV);
  assign o_res = r_acc[2:0];

endmodule

// File: rtl/keccak_pi_slice_engine.sv
// Bit-serial Keccak pi permutation over one 25-bit slice per accepted count.
// Define MOD_LUT_EN to bypass the REDUCE state (77-cycle slice latency).
module keccak_pi_slice_engine
  import keccak_pi_pkg::*;
#(
  parameter int DIM = 5,
  parameter int CW  = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DIM*DIM-1:0]   line,
  input  logic [CW-1:0]        count,
  output logic [DIM*DIM-1:0]   mem,
  output logic                 done,
  output logic                 busy
);

  state_t             r_state;
  logic [2:0]         r_i;
  logic [2:0]         r_j;
  logic               r_seen;
  logic [CW-1:0]      r_cnt;
  logic [DIM*DIM-1:0] r_line;
  logic [DIM*DIM-1:0] r_work;
  logic [DIM*DIM-1:0] r_mem;
  logic               r_done;
  logic               r_busy;

  logic               w_accept;
  logic [2:0]         w_res;
  logic               w_ge5;
  logic [4:0]         w_src;
  logic [4:0]         w_dst;

  // A slice is new if nothing has been accepted since reset or its index moved.
  assign w_accept = (r_state == IDLE) && start && (!r_seen || (count != r_cnt));
  assign w_src    = idx(r_i, r_j);
  assign w_dst    = idx(r_j, w_res);

  pi_mod5_unit u_mod5 (
    .clk      (clk),
    .i_calc   (r_state == CALC),
    .i_reduce (r_state == REDUCE),
    .i_i      (r_i),
    .i_j      (r_j),
    .o_res    (w_res),
    .o_ge5    (w_ge5)
  );

  // Control FSM, cell counters and published result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_i     <= 3'd0;
      r_j     <= 3'd0;
      r_seen  <= 1'b0;
      r_cnt   <= '0;
      r_mem   <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_seen  <= 1'b1;
            r_cnt   <= count;
            r_busy  <= 1'b1;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_i     <= 3'd0;
          r_j     <= 3'd0;
          r_state <= CALC;
        end
        CALC: begin
`ifdef MOD_LUT_EN
          r_state <= WRITE;
`else
          r_state <= REDUCE;
`endif
        end
        REDUCE: begin
          if (!w_ge5) r_state <= WRITE;
        end
        WRITE: begin
          r_state <= NEXT;
        end
        NEXT: begin
          if (r_j == 3'd4) begin
            r_j <= 3'd0;
            if (r_i == 3'd4) begin
              r_i     <= 3'd0;
              r_state <= FIN;
            end else begin
              r_i     <= r_i + 3'd1;
              r_state <= CALC;
            end
          end else begin
            r_j     <= r_j + 3'd1;
            r_state <= CALC;
          end
        end
        FIN: begin
          r_mem   <= r_work;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Datapath: latched input slice and the partially permuted working copy.
  always_ff @(posedge clk) begin
    if (w_accept) r_line <= line;
    if (r_state == LOAD) begin
      r_work <= '0;
    end else if (r_state == WRITE) begin
      r_work[w_dst] <= r_line[w_src];
    end
  end

  assign mem  = r_mem;
  assign done = r_done;
  assign busy = r_busy;

endmodule

// File: tb/tb_keccak_pi_slice_engine.sv
// Scoreboard bench for keccak_pi_slice_engine: expected slices queued on drive, checked on done.
module tb_keccak_pi_slice_engine;

  logic        clk;
  logic        rst;
  logic        start;
  logic [24:0] line;
  logic [5:0]  count;
  logic [24:0] mem;
  logic        done;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int n_done = 0;
  int n_unexp = 0;
  logic [24:0] exp_q[$];

  keccak_pi_slice_engine #(.DIM(5), .CW(6)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .line  (line),
    .count (count),
    .mem   (mem),
    .done  (done),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [24:0] pi_ref(input logic [24:0] a);
    logic [24:0] o;
    o = '0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        o[5*j + ((2*i + 3*j) % 5)] = a[5*i + j];
    return o;
  endfunction

  // Scoreboard side: every done pulse consumes one expected slice.
  always @(posedge clk) begin
    #1;
    if (done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        n_unexp++;
      end else begin
        check_eq("mem", 32'(mem), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic run_slice(input logic [24:0] ln, input logic [5:0] cn, input logic [24:0] ex);
    int n;
    bit busy_ok;
    @(posedge clk); #1;
    line  = ln;
    count = cn;
    start = 1'b1;
    exp_q.push_back(ex);
    n = 0;
    busy_ok = 1'b1;
    do begin
      @(posedge clk); #1;
      n++;
      if (!done && !busy) busy_ok = 1'b0;
    end while (!done && n < 300);
    check_eq("done_seen", 32'(done), 32'd1);
    check_eq("busy_high", 32'(busy_ok), 32'd1);
`ifdef MOD_LUT_EN
    check_eq("latency", 32'(n), 32'd77);
`else
    check_eq("latency_le256", 32'(n <= 256), 32'd1);
`endif
    @(posedge clk); #1;
    check_eq("done_pulse", 32'(done), 32'd0);
    repeat (500 - n - 1) @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [24:0] r;
    int d0;
    rst   = 1'b1;
    start = 1'b0;
    line  = '0;
    count = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("rst_mem", 32'(mem), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);

    run_slice(25'h0000000, 6'd0, 25'h0000000);
    run_slice(25'h1FFFFFF, 6'd1, 25'h1FFFFFF);
    run_slice(25'h0000001, 6'd2, 25'h0000001);
    run_slice(25'h0000020, 6'd3, 25'h0000004);
    run_slice(25'h0000002, 6'd4, 25'h0000100);
    run_slice(25'h1000000, 6'd5, 25'h0100000);

    // Same count held with start high: no reprocessing even if line moves.
    d0 = n_done;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      if (c == 100) line = 25'h0ABCDEF;
      if (c == 300) line = 25'h1555555;
    end
    check_eq("no_retrigger", 32'(n_done), 32'(d0));
    check_eq("mem_held", 32'(mem), 32'h0100000);

    // Abort a slice with a one-cycle reset mid-flight.
    r = 25'($urandom);
    @(posedge clk); #1;
    line  = r;
    count = 6'd6;
    repeat (50) @(posedge clk);
    #1;
    check_eq("busy_mid", 32'(busy), 32'd1);
    rst   = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("abort_mem", 32'(mem), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    d0 = n_done;
    repeat (5) @(posedge clk);
    #1;
    check_eq("abort_no_done", 32'(n_done), 32'(d0));
    run_slice(r, 6'd6, pi_ref(r));

    for (int k = 0; k < 64; k++) begin
      r = 25'($urandom);
      run_slice(r, 6'(k), pi_ref(r));
    end

    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    check_eq("spurious_done", 32'(n_unexp), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
